// File: rtl/hazard_pkg.sv
// Shared defaults and forwarding-select encodings for the hazard controller
// and its scoreboard.
package hazard_pkg;

  localparam int DEF_NREG = 16;
  localparam int DEF_AW   = 4;
  localparam int DEF_CW   = 16;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Snapshot of every control decision taken in one cycle, for debug visibility.
  typedef struct packed {
    logic load_use;
    logic score_stall;
    logic stall;
    logic branch;
  } hazard_dbg_t;

endpackage

// File: rtl/hazard_unit_sb_if.sv
// Pipeline-to-hazard-unit signal bundle: the datapath (master) presents stage
// addresses and controls, the hazard unit (slave) returns stall/flush/forward.
interface hazard_unit_sb_if
  import hazard_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int AW   = DEF_AW,
  parameter int CW   = DEF_CW
);
  // Decode stage
  logic [AW-1:0]   RA1D, RA2D, WA3D;
  logic            RegWriteD, MStartD;
  // Execute stage
  logic [AW-1:0]   RA1E, RA2E, WA3E;
  logic            RegWriteE, MemtoRegE, MStartE, PCSrcE;
  // Memory and writeback stages
  logic [AW-1:0]   WA3M, RA2M, WA3W;
  logic            RegWriteM, MemWriteM, RegWriteW, MemtoRegW;
  // MCycle unit
  logic            MBusy, MDone;
  logic [AW-1:0]   MWA;
  logic            StallCntClr;
  // Hazard unit responses
  logic            StallF, StallD, FlushD, FlushE, FlushM;
  logic [1:0]      ForwardAE, ForwardBE;
  logic            ForwardM;
  logic [NREG-1:0] Pending;
  logic [CW-1:0]   StallCount;
  hazard_dbg_t     dbg;

  modport master (
    output RA1D, RA2D, WA3D, RegWriteD, MStartD,
    output RA1E, RA2E, WA3E, RegWriteE, MemtoRegE, MStartE, PCSrcE,
    output WA3M, RA2M, WA3W, RegWriteM, MemWriteM, RegWriteW, MemtoRegW,
    output MBusy, MDone, MWA, StallCntClr,
    input  StallF, StallD, FlushD, FlushE, FlushM,
    input  ForwardAE, ForwardBE, ForwardM, Pending, StallCount, dbg
  );

  modport slave (
    input  RA1D, RA2D, WA3D, RegWriteD, MStartD,
    input  RA1E, RA2E, WA3E, RegWriteE, MemtoRegE, MStartE, PCSrcE,
    input  WA3M, RA2M, WA3W, RegWriteM, MemWriteM, RegWriteW, MemtoRegW,
    input  MBusy, MDone, MWA, StallCntClr,
    output StallF, StallD, FlushD, FlushE, FlushM,
    output ForwardAE, ForwardBE, ForwardM, Pending, StallCount, dbg
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write bitmap for results still owed by the MCycle unit.
// A set and a clear hitting the same register in one cycle leaves it pending.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int AW   = DEF_AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en,
  input  logic [AW-1:0]   set_idx,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_idx,
  output logic [NREG-1:0] pending
);

  logic [NREG-1:0] pending_nxt;

  // Indices at or above NREG simply match no bit.
  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < NREG; i++) begin
      if (clr_en && clr_idx == AW'(i)) pending_nxt[i] = 1'b0;
      if (set_en && set_idx == AW'(i)) pending_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

endmodule

// File: rtl/hazard_unit_sb.sv
// 5-stage pipeline hazard controller: forwarding selects, load-use and
// scoreboard stalls for out-of-order MCycle results, and a stall-cycle counter.
module hazard_unit_sb
  import hazard_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int AW   = DEF_AW,
  parameter int CW   = DEF_CW
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  hazard_unit_sb_if.slave      bus
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [NREG-1:0] pending;
  logic [CW-1:0]   stall_count;
  logic            load_use;
  logic            score_stall;
  logic            stall;

  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] ra);
    if (bus.RegWriteM && ra == bus.WA3M)      return FWD_M;
    else if (bus.RegWriteW && ra == bus.WA3W) return FWD_W;
    else                                      return FWD_RF;
  endfunction

  function automatic logic pend_rd(input logic [AW-1:0] addr);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NREG; i++)
      if (addr == AW'(i)) hit = pending[i];
    return hit;
  endfunction

  hazard_scoreboard #(.NREG(NREG), .AW(AW)) u_scoreboard (
    .clk     (CLK),
    .rst_n   (RESETn),
    .set_en  (bus.MStartE && bus.RegWriteE),
    .set_idx (bus.WA3E),
    .clr_en  (bus.MDone),
    .clr_idx (bus.MWA),
    .pending (pending)
  );

  always_comb begin
    load_use = (bus.RA1D == bus.WA3E || bus.RA2D == bus.WA3E)
               && bus.MemtoRegE && bus.RegWriteE;
    score_stall = pend_rd(bus.RA1D) || pend_rd(bus.RA2D)
                  || (bus.RegWriteD && pend_rd(bus.WA3D))
                  || (bus.MStartD && (bus.MBusy || bus.MStartE));
    // A taken branch wins so the target fetch is not held off.
    stall = (load_use || score_stall) && !bus.PCSrcE;
  end

  assign bus.ForwardAE  = fwd_sel(bus.RA1E);
  assign bus.ForwardBE  = fwd_sel(bus.RA2E);
  assign bus.ForwardM   = (bus.RA2M == bus.WA3W) && bus.MemWriteM
                          && bus.MemtoRegW && bus.RegWriteW;
  assign bus.StallF     = stall;
  assign bus.StallD     = stall;
  assign bus.FlushD     = bus.PCSrcE;
  assign bus.FlushE     = load_use || score_stall || bus.PCSrcE;
  // The MCycle op leaves E as a bubble; its result comes back via MDone.
  assign bus.FlushM     = bus.MStartE;
  assign bus.Pending    = pending;
  assign bus.StallCount = stall_count;
  assign bus.dbg        = '{load_use: load_use, score_stall: score_stall,
                            stall: stall, branch: bus.PCSrcE};

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)                                stall_count <= '0;
    else if (bus.StallCntClr)                   stall_count <= '0;
    else if (stall && stall_count != CNT_MAX)   stall_count <= stall_count + CW'(1);
  end

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Bench for hazard_unit_sb: directed hazard scenarios plus random traffic,
// all outputs checked each cycle against an abstract reference model.
module tb_hazard_unit_sb;
  import hazard_pkg::*;

  localparam int NREG = 16;
  localparam int AW   = 4;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic            stall_f, stall_d, flush_d, flush_e, flush_m;
    logic [1:0]      fwd_a, fwd_b;
    logic            fwd_m;
    logic [NREG-1:0] pending;
    logic [CW-1:0]   count;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic clk = 1'b0;
  logic rst_n;
  logic mon_en = 1'b0;
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  bit m_pend[NREG];
  int m_cnt;

  hazard_unit_sb_if #(.NREG(NREG), .AW(AW), .CW(CW)) bus ();
  hazard_unit_sb #(.NREG(NREG), .AW(AW), .CW(CW)) dut (
    .CLK(clk), .RESETn(rst_n), .bus(bus.slave)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not end, actual=timeout required=finish");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pend_at(input logic [AW-1:0] a);
    if (int'(a) < NREG) return m_pend[a];
    return 1'b0;
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [AW-1:0] ra);
    if (bus.RegWriteM && ra == bus.WA3M) return 2'd2;
    if (bus.RegWriteW && ra == bus.WA3W) return 2'd1;
    return 2'd0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    bit lu, ss, stl;
    lu  = (bus.RA1D == bus.WA3E || bus.RA2D == bus.WA3E) && bus.MemtoRegE && bus.RegWriteE;
    ss  = pend_at(bus.RA1D) || pend_at(bus.RA2D) || (bus.RegWriteD && pend_at(bus.WA3D))
          || (bus.MStartD && (bus.MBusy || bus.MStartE));
    stl = (lu || ss) && !bus.PCSrcE;
    e.stall_f = stl;
    e.stall_d = stl;
    e.flush_d = bus.PCSrcE;
    e.flush_e = lu || ss || bus.PCSrcE;
    e.flush_m = bus.MStartE;
    e.fwd_a   = fwd_ref(bus.RA1E);
    e.fwd_b   = fwd_ref(bus.RA2E);
    e.fwd_m   = (bus.RA2M == bus.WA3W) && bus.MemWriteM && bus.MemtoRegW && bus.RegWriteW;
    for (int i = 0; i < NREG; i++) e.pending[i] = m_pend[i];
    e.count   = CW'(m_cnt);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_step(input bit stl);
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (bus.MDone && int'(bus.MWA) < NREG) m_pend[bus.MWA] = 1'b0;
    if (bus.MStartE && bus.RegWriteE && int'(bus.WA3E) < NREG) m_pend[bus.WA3E] = 1'b1;
    if (bus.StallCntClr) m_cnt = 0;
    else if (stl)        m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
  endtask

  // ---------------- driver ----------------
  task automatic idle();
    bus.RA1D = '0; bus.RA2D = '0; bus.WA3D = '0; bus.RegWriteD = 0; bus.MStartD = 0;
    bus.RA1E = '0; bus.RA2E = '0; bus.WA3E = '0;
    bus.RegWriteE = 0; bus.MemtoRegE = 0; bus.MStartE = 0; bus.PCSrcE = 0;
    bus.WA3M = '0; bus.RA2M = '0; bus.WA3W = '0;
    bus.RegWriteM = 0; bus.MemWriteM = 0; bus.RegWriteW = 0; bus.MemtoRegW = 0;
    bus.MBusy = 0; bus.MDone = 0; bus.MWA = '0; bus.StallCntClr = 0;
  endtask

  // Called about 1 time unit after a rising edge with inputs already applied.
  task automatic cycle();
    exp_t e;
    e = model_out();
    exp_q.push_back(EW'(e));
    @(posedge clk);
    model_step(e.stall_d);
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic rand_inputs();
    bus.RA1D = rand_addr(); bus.RA2D = rand_addr(); bus.WA3D = rand_addr();
    bus.RegWriteD = 1'($urandom_range(0, 1));
    bus.MStartD   = ($urandom_range(0, 5) == 0);
    bus.RA1E = rand_addr(); bus.RA2E = rand_addr(); bus.WA3E = rand_addr();
    bus.RegWriteE = 1'($urandom_range(0, 1));
    bus.MemtoRegE = ($urandom_range(0, 2) == 0);
    bus.MStartE   = ($urandom_range(0, 5) == 0);
    bus.PCSrcE    = !bus.MStartE && ($urandom_range(0, 9) == 0);
    bus.WA3M = rand_addr(); bus.RA2M = rand_addr(); bus.WA3W = rand_addr();
    bus.RegWriteM = 1'($urandom_range(0, 1)); bus.MemWriteM = 1'($urandom_range(0, 1));
    bus.RegWriteW = 1'($urandom_range(0, 1)); bus.MemtoRegW = 1'($urandom_range(0, 1));
    bus.MBusy = 1'($urandom_range(0, 1));
    bus.MDone = ($urandom_range(0, 3) == 0);
    bus.MWA   = rand_addr();
    bus.StallCntClr = ($urandom_range(0, 49) == 0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          chk("queue_underflow", 0, 1);
        end else begin
          exp_t e;
          e = exp_t'(exp_q.pop_front());
          chk("StallF",     int'(bus.StallF),     int'(e.stall_f));
          chk("StallD",     int'(bus.StallD),     int'(e.stall_d));
          chk("FlushD",     int'(bus.FlushD),     int'(e.flush_d));
          chk("FlushE",     int'(bus.FlushE),     int'(e.flush_e));
          chk("FlushM",     int'(bus.FlushM),     int'(e.flush_m));
          chk("ForwardAE",  int'(bus.ForwardAE),  int'(e.fwd_a));
          chk("ForwardBE",  int'(bus.ForwardBE),  int'(e.fwd_b));
          chk("ForwardM",   int'(bus.ForwardM),   int'(e.fwd_m));
          chk("Pending",    int'(bus.Pending),    int'(e.pending));
          chk("StallCount", int'(bus.StallCount), int'(e.count));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    idle();
    model_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_Pending",    int'(bus.Pending),    0);
    chk("reset_StallCount", int'(bus.StallCount), 0);
    chk("reset_StallD",     int'(bus.StallD),     0);
    chk("reset_ForwardAE",  int'(bus.ForwardAE),  0);
    @(posedge clk); #1;
    mon_en = 1'b1;
    cycle();
    rst_n = 1'b1;
    cycle();

    // Forwarding priority: M over W, then W alone, store-data forward.
    idle();
    bus.WA3M = 4'd3; bus.RegWriteM = 1; bus.WA3W = 4'd3; bus.RegWriteW = 1; bus.RA1E = 4'd3;
    #1 chk("fwd_m_prio", int'(bus.ForwardAE), 2);
    cycle();
    bus.RegWriteM = 0;
    #1 chk("fwd_w", int'(bus.ForwardAE), 1);
    cycle();
    bus.RA2M = 4'd3; bus.MemWriteM = 1; bus.MemtoRegW = 1; bus.RA2E = 4'd3;
    #1 chk("fwd_store", int'(bus.ForwardM), 1);
    cycle();

    // MCycle issue to R5, then dependent read stalls until MDone plus one.
    idle();
    bus.MStartE = 1; bus.WA3E = 4'd5; bus.RegWriteE = 1;
    #1 chk("mstart_flushm", int'(bus.FlushM), 1);
    cycle();
    idle(); bus.MBusy = 1; bus.RA1D = 4'd1; bus.RA2D = 4'd2;
    #1 chk("indep_no_stall", int'(bus.StallD), 0);
    cycle();
    bus.MStartD = 1;
    #1 chk("struct_stall", int'(bus.StallD), 1);
    cycle();
    idle(); bus.MBusy = 1; bus.RA2D = 4'd5;
    for (int k = 0; k < 4; k++) begin
      #1 chk("raw_stall", int'(bus.StallF & bus.StallD & bus.FlushE), 1);
      cycle();
    end
    bus.MBusy = 0; bus.MDone = 1; bus.MWA = 4'd5;
    #1 chk("mdone_cycle_stall", int'(bus.StallD), 1);
    cycle();
    bus.MDone = 0;
    #1 chk("released", int'(bus.StallD), 0);
    cycle();

    // Load-use, with and without a simultaneous branch.
    idle();
    bus.RA1D = 4'd7; bus.WA3E = 4'd7; bus.MemtoRegE = 1; bus.RegWriteE = 1;
    #1 chk("load_use", int'(bus.StallD), 1);
    cycle();
    bus.PCSrcE = 1;
    #1 chk("branch_override", int'({bus.StallF, bus.StallD, bus.FlushD, bus.FlushE}), 4'b0011);
    cycle();

    // Same-cycle set and clear on R6 leaves it pending.
    idle();
    bus.MStartE = 1; bus.RegWriteE = 1; bus.WA3E = 4'd6; bus.MDone = 1; bus.MWA = 4'd6;
    cycle();
    idle(); bus.MDone = 1; bus.MWA = 4'd6;
    cycle();

    // Counter saturation and clear-over-increment.
    idle(); bus.StallCntClr = 1;
    cycle();
    idle(); bus.MStartE = 1; bus.RegWriteE = 1; bus.WA3E = 4'd2;
    cycle();
    idle(); bus.RA1D = 4'd2;
    for (int k = 0; k < CMAX + 5; k++) cycle();
    chk("count_saturated", int'(bus.StallCount), CMAX);
    bus.StallCntClr = 1;
    cycle();
    chk("count_cleared", int'(bus.StallCount), 0);
    idle(); bus.MDone = 1; bus.MWA = 4'd2;
    cycle();

    // Asynchronous reset mid-cycle with R4 pending.
    idle(); bus.MStartE = 1; bus.RegWriteE = 1; bus.WA3E = 4'd4;
    cycle();
    idle(); bus.RA1D = 4'd4;
    #1 chk("pre_reset_pending", int'(bus.Pending), 16'h0010);
    chk("pre_reset_stall", int'(bus.StallD), 1);
    rst_n = 1'b0;
    #1 chk("async_Pending",    int'(bus.Pending),    0);
    chk("async_StallCount",    int'(bus.StallCount), 0);
    chk("async_StallD",        int'(bus.StallD),     0);
    model_reset();
    cycle();
    rst_n = 1'b1;
    idle();
    cycle();

    // Random traffic.
    for (int k = 0; k < 2000; k++) begin
      rand_inputs();
      cycle();
    end

    idle();
    cycle();
    mon_en = 1'b0;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
